// File: rtl/ahb_slave_arbiter_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_slave_arbiter_rr_pkg
//  Brief    : AHB transfer/burst encodings and arbiter state type.
//  Revision : 1.0 - initial release
// ============================================================================
package ahb_slave_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BURST = 2'd2
    } arb_state_e;

    localparam int c_beat_w = 4;

    // 0 marks an undefined-length INCR burst
    function automatic logic [4:0] burst_len(input hburst_e burst);
        case (burst)
            HBURST_SINGLE:                burst_len = 5'd1;
            HBURST_INCR:                  burst_len = 5'd0;
            HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
            default:                      burst_len = 5'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_rr_pick
//  Brief    : Combinational picker: highest priority wins, ties resolved
//             round-robin starting after the pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int PRIO_W      = 2,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS*PRIO_W-1:0] prio,
    input  logic [IDX_W-1:0]              ptr,
    output logic [NUM_MASTERS-1:0]        winner
);

    logic [PRIO_W-1:0]      w_max;
    logic [NUM_MASTERS-1:0] w_cand;
    logic                   w_found;
    logic [IDX_W-1:0]       w_idx;

    always_comb begin
        w_max = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (req[i] && (prio[i*PRIO_W +: PRIO_W] > w_max)) begin
                w_max = prio[i*PRIO_W +: PRIO_W];
            end
        end

        w_cand = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_cand[i] = req[i] && (prio[i*PRIO_W +: PRIO_W] == w_max);
        end

        // Scan ptr+1, ptr+2, ... wrapping; the last slot visited is ptr itself
        winner  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_idx = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
            if (!w_found && w_cand[w_idx]) begin
                winner[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_slave_arbiter_rr
//  Brief    : Per-slave-port AHB arbiter, priority + round-robin, burst hold,
//             separate data-phase owner. Optional starvation override is
//             enabled with `define AHB_ARB_STARVE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_arbiter_rr
    import ahb_slave_arbiter_rr_pkg::*;
#(
    parameter int  NUM_MASTERS  = 4,
    parameter int  PRIO_W       = 2,
    parameter int  STARVE_LIMIT = 32,
    localparam int IDX_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic [NUM_MASTERS-1:0]        hreq,
    input  logic [NUM_MASTERS*PRIO_W-1:0] hprior,
    input  logic [1:0]                    htrans,
    input  logic [2:0]                    hburst,
    input  logic                          hreadyout,
    output logic [NUM_MASTERS-1:0]        hgrant,
    output logic                          hsel,
    output logic [IDX_W-1:0]              hmaster,
    output logic [NUM_MASTERS-1:0]        hdata_own
);

    arb_state_e             r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0]       r_ptr, w_ptr_nxt;
    logic [c_beat_w-1:0]    r_beat_cnt, w_beat_cnt_nxt;
    logic                   r_incr, w_incr_nxt;
    logic [NUM_MASTERS-1:0] r_data_own;

    logic [NUM_MASTERS-1:0] w_pick_req;
    logic [NUM_MASTERS-1:0] w_winner;
    logic                   w_rearb;
    logic                   w_new_xfer;
    logic [4:0]             w_len;
    htrans_e                w_trans;
    hburst_e                w_burst;
    logic                   w_owner_req;

    function automatic logic [IDX_W-1:0] f_encode(input logic [NUM_MASTERS-1:0] onehot);
        logic [IDX_W-1:0] w_idx;
        w_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (onehot[i]) w_idx = IDX_W'(i);
        end
        return w_idx;
    endfunction

    assign w_trans     = htrans_e'(htrans);
    assign w_burst     = hburst_e'(hburst);
    assign w_owner_req = |(hreq & r_grant);

`ifdef AHB_ARB_STARVE_EN
    localparam int               c_wait_w  = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_wait_w-1:0] c_limit = c_wait_w'(STARVE_LIMIT);

    logic [NUM_MASTERS-1:0] w_starved;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_wait
        logic [c_wait_w-1:0] r_wait;

        always_ff @(posedge hclk or posedge hreset) begin
            if (hreset) begin
                r_wait <= '0;
            end else if (!hreq[gi] || r_grant[gi]) begin
                r_wait <= '0;
            end else if (r_wait < c_limit) begin
                r_wait <= r_wait + c_wait_w'(1);
            end
        end

        assign w_starved[gi] = hreq[gi] && (r_wait >= c_limit);
    end

    // Lowest-index starved master is presented to the picker alone
    assign w_pick_req = (|w_starved) ? (w_starved & (~w_starved + NUM_MASTERS'(1))) : hreq;
`else
    assign w_pick_req = hreq;
`endif

    ahb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .PRIO_W      (PRIO_W),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req    (w_pick_req),
        .prio   (hprior),
        .ptr    (r_ptr),
        .winner (w_winner)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_incr_nxt     = r_incr;
        w_rearb        = 1'b0;
        w_new_xfer     = 1'b0;
        w_len          = burst_len(w_burst);

        if (hreadyout) begin
            case (r_state)
                ARB_IDLE: w_rearb = 1'b1;
                ARB_GRANT: begin
                    if (w_trans == HTRANS_NONSEQ)    w_new_xfer = 1'b1;
                    else if (w_trans == HTRANS_IDLE) w_rearb    = 1'b1;
                end
                ARB_BURST: begin
                    if (w_trans == HTRANS_NONSEQ)    w_new_xfer = 1'b1;
                    else if (w_trans == HTRANS_IDLE) w_rearb    = 1'b1;
                    else if (r_incr) begin
                        if (!w_owner_req) w_rearb = 1'b1;
                    end else if (w_trans == HTRANS_SEQ) begin
                        // beat count holds SEQ beats still to be accepted
                        if (r_beat_cnt <= c_beat_w'(1)) w_rearb = 1'b1;
                        else w_beat_cnt_nxt = r_beat_cnt - c_beat_w'(1);
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase

            if (w_new_xfer) begin
                if (w_len == 5'd1) begin
                    w_rearb = 1'b1;
                end else begin
                    w_state_nxt    = ARB_BURST;
                    w_incr_nxt     = (w_len == 5'd0);
                    w_beat_cnt_nxt = c_beat_w'(w_len - 5'd1);
                end
            end

            if (w_rearb) begin
                if (|hreq) begin
                    w_state_nxt = ARB_GRANT;
                    w_grant_nxt = w_winner;
                    w_ptr_nxt   = f_encode(w_winner);
                end else begin
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_ptr      <= IDX_W'(NUM_MASTERS - 1);
            r_beat_cnt <= '0;
            r_incr     <= 1'b0;
            r_data_own <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_incr     <= w_incr_nxt;
            if (hreadyout) r_data_own <= r_grant & {NUM_MASTERS{htrans[1]}};
        end
    end

    assign hgrant    = r_grant;
    assign hsel      = |r_grant;
    assign hmaster   = f_encode(r_grant);
    assign hdata_own = r_data_own;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_slave_arbiter_rr
//  Brief    : Directed scenarios plus randomized run against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_arbiter_rr;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int SL = 8;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

    logic          hclk = 1'b0;
    logic          hreset;
    logic [N-1:0]  hreq;
    logic [N*PW-1:0] hprior;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic          hreadyout;
    logic [N-1:0]  hgrant;
    logic          hsel;
    logic [1:0]    hmaster;
    logic [N-1:0]  hdata_own;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: owner/data owner as indices, -1 = none
    int m_owner, m_data, m_ptr, m_left;
    bit m_locked, m_undef;
    int m_wait[N];
    int lens[8] = '{1, 0, 4, 4, 8, 8, 16, 16};

    ahb_slave_arbiter_rr #(
        .NUM_MASTERS  (N),
        .PRIO_W       (PW),
        .STARVE_LIMIT (SL)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hreq      (hreq),
        .hprior    (hprior),
        .htrans    (htrans),
        .hburst    (hburst),
        .hreadyout (hreadyout),
        .hgrant    (hgrant),
        .hsel      (hsel),
        .hmaster   (hmaster),
        .hdata_own (hdata_own)
    );

    always #5 hclk = ~hclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset = 1'b1; hreq = '0; hprior = '0; htrans = T_IDLE; hburst = 3'd0; hreadyout = 1'b1;
        step();
        step();
        hreset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (hgrant !== 4'b0)    begin n_err++; $display("FAIL reset_hgrant got %b want 0000", hgrant); end
        n_vec++; if (hsel !== 1'b0)      begin n_err++; $display("FAIL reset_hsel got %b want 0", hsel); end
        n_vec++; if (hmaster !== 2'd0)   begin n_err++; $display("FAIL reset_hmaster got %0d want 0", hmaster); end
        n_vec++; if (hdata_own !== 4'b0) begin n_err++; $display("FAIL reset_hdata_own got %b want 0000", hdata_own); end
        hreq = 4'hF; hprior = 8'h55; htrans = T_NSEQ;
        repeat (3) step();
        n_vec++; if (hgrant === 4'b0) begin n_err++; $display("FAIL active_before_reset got %b want nonzero", hgrant); end
        #2 hreset = 1'b1;
        #1;
        n_vec++; if (hgrant !== 4'b0)    begin n_err++; $display("FAIL async_reset_hgrant got %b want 0000", hgrant); end
        n_vec++; if (hsel !== 1'b0)      begin n_err++; $display("FAIL async_reset_hsel got %b want 0", hsel); end
        n_vec++; if (hdata_own !== 4'b0) begin n_err++; $display("FAIL async_reset_hdata_own got %b want 0000", hdata_own); end
        hreq = '0;
        step();
        hreset = 1'b0;
        repeat (3) step();
        n_vec++; if (hgrant !== 4'b0 || hsel !== 1'b0 || hdata_own !== 4'b0) begin
            n_err++; $display("FAIL post_reset_idle got grant=%b sel=%b own=%b want 0000/0/0000", hgrant, hsel, hdata_own);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        hprior = 8'b01_01_01_01; hreq = 4'hF; htrans = T_NSEQ; hburst = 3'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++; if (hgrant !== exp_seq[i]) begin n_err++; $display("FAIL rr_grant[%0d] got %b want %b", i, hgrant, exp_seq[i]); end
            n_vec++; if (hmaster !== 2'(i % 4)) begin n_err++; $display("FAIL rr_hmaster[%0d] got %0d want %0d", i, hmaster, i % 4); end
        end
    endtask

    task automatic test_priority();
        do_reset();
        hprior = 8'b00_11_00_01; hreq = 4'b0101; htrans = T_NSEQ; hburst = 3'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_vec++; if (hgrant !== 4'b0100) begin n_err++; $display("FAIL prio_grant[%0d] got %b want 0100", i, hgrant); end
        end
    endtask

    task automatic test_burst_hold();
        logic [N-1:0] exp_g;
        do_reset();
        hprior = 8'h55; hreq = 4'b1010; htrans = T_IDLE;
        step();
        n_vec++; if (hgrant !== 4'b0010) begin n_err++; $display("FAIL burst_first_grant got %b want 0010", hgrant); end
        hburst = 3'd5;
        for (int b = 1; b <= 8; b++) begin
            htrans = (b == 1) ? T_NSEQ : T_SEQ;
            if (b == 3) begin
                hreadyout = 1'b0;
                repeat (2) begin
                    step();
                    n_vec++; if (hgrant !== 4'b0010) begin n_err++; $display("FAIL burst_wait_grant got %b want 0010", hgrant); end
                end
                hreadyout = 1'b1;
            end
            step();
            exp_g = (b == 8) ? 4'b1000 : 4'b0010;
            n_vec++; if (hgrant !== exp_g) begin n_err++; $display("FAIL burst_beat%0d_grant got %b want %b", b, hgrant, exp_g); end
        end
        n_vec++; if (hdata_own !== 4'b0010) begin n_err++; $display("FAIL burst_last_data_own got %b want 0010", hdata_own); end
        htrans = T_IDLE; hreq = '0;
        step();
    endtask

    task automatic test_data_phase();
        do_reset();
        hprior = 8'h55; hreq = 4'b0001; htrans = T_IDLE; hburst = 3'd0;
        step();
        n_vec++; if (hgrant !== 4'b0001) begin n_err++; $display("FAIL dp_grant0 got %b want 0001", hgrant); end
        hreq = 4'b0100; htrans = T_NSEQ;
        step();
        n_vec++; if (hgrant !== 4'b0100)    begin n_err++; $display("FAIL dp_grant2 got %b want 0100", hgrant); end
        n_vec++; if (hdata_own !== 4'b0001) begin n_err++; $display("FAIL dp_own0 got %b want 0001", hdata_own); end
        hreadyout = 1'b0;
        repeat (3) begin
            step();
            n_vec++; if (hdata_own !== 4'b0001 || hgrant !== 4'b0100) begin
                n_err++; $display("FAIL dp_stall got own=%b grant=%b want 0001/0100", hdata_own, hgrant);
            end
        end
        hreadyout = 1'b1;
        step();
        n_vec++; if (hdata_own !== 4'b0100) begin n_err++; $display("FAIL dp_own2 got %b want 0100", hdata_own); end
    endtask

    task automatic test_starvation();
        int first;
        first = -1;
        do_reset();
        hprior = 8'b11_00_00_00; hreq = 4'b1001; htrans = T_NSEQ; hburst = 3'd0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (hgrant[0] && first < 0) first = c;
        end
`ifdef AHB_ARB_STARVE_EN
        n_vec++; if (first < 1 || first > SL + 1) begin n_err++; $display("FAIL starve_m0_grant_cycle got %0d want 1..%0d", first, SL + 1); end
`else
        n_vec++; if (first != -1) begin n_err++; $display("FAIL starve_m0_never got cycle %0d want never", first); end
`endif
    endtask

    function automatic int model_pick();
`ifdef AHB_ARB_STARVE_EN
        for (int i = 0; i < N; i++) if (hreq[i] && m_wait[i] >= SL) return i;
`endif
        for (int p = (1 << PW) - 1; p >= 0; p--) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (hreq[i] && int'(hprior[i*PW +: PW]) == p) return i;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_data = -1; m_ptr = N - 1; m_left = 0; m_locked = 0; m_undef = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    // advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        int old_owner, len;
        bit rearb, start;
        old_owner = m_owner; rearb = 0; start = 0;
        if (hreadyout) begin
            m_data = (m_owner >= 0 && htrans[1]) ? m_owner : -1;
            if (m_owner < 0)              rearb = 1;
            else if (htrans == T_NSEQ)    start = 1;
            else if (htrans == T_IDLE)    rearb = 1;
            else if (m_locked) begin
                if (m_undef) begin
                    if (!hreq[m_owner]) rearb = 1;
                end else if (htrans == T_SEQ) begin
                    m_left--;
                    if (m_left == 0) rearb = 1;
                end
            end
            if (start) begin
                len = lens[hburst];
                if (len == 1) rearb = 1;
                else begin m_locked = 1; m_undef = (len == 0); m_left = len - 1; end
            end
            if (rearb) begin
                m_locked = 0;
                m_owner = model_pick();
                if (m_owner >= 0) m_ptr = m_owner;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!hreq[i] || old_owner == i) m_wait[i] = 0;
            else if (m_wait[i] < SL)        m_wait[i]++;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_g, exp_d;
        int t;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            hreq = 4'($urandom_range(0, 15));
            if (cyc % 16 == 0) hprior = 8'($urandom);
            hreadyout = ($urandom_range(0, 3) != 0);
            hburst = 3'($urandom_range(0, 7));
            if (m_locked) begin
                t = $urandom_range(0, 9);
                htrans = (t == 0) ? T_IDLE : (t == 1) ? T_NSEQ : (t < 4) ? T_BUSY : T_SEQ;
            end else begin
                htrans = ($urandom_range(0, 3) == 0) ? T_IDLE : T_NSEQ;
            end
            model_step();
            step();
            exp_g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
            exp_d = (m_data >= 0) ? 4'(1 << m_data) : 4'b0;
            n_vec++; if (hgrant !== exp_g) begin n_err++; $display("FAIL rand_hgrant cyc %0d got %b want %b", cyc, hgrant, exp_g); end
            n_vec++; if (hsel !== (m_owner >= 0)) begin n_err++; $display("FAIL rand_hsel cyc %0d got %b want %b", cyc, hsel, m_owner >= 0); end
            n_vec++; if (hmaster !== 2'((m_owner >= 0) ? m_owner : 0)) begin
                n_err++; $display("FAIL rand_hmaster cyc %0d got %0d want %0d", cyc, hmaster, (m_owner >= 0) ? m_owner : 0);
            end
            n_vec++; if (hdata_own !== exp_d) begin n_err++; $display("FAIL rand_hdata_own cyc %0d got %b want %b", cyc, hdata_own, exp_d); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_priority();
        test_burst_hold();
        test_data_phase();
        test_starvation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
